// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Double-buffered 8N1 UART transmitter, LSB first. Raises an
//            end-of-frame interrupt pulse after each stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_write,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       tx_int,
    output logic       uart_out
);

    localparam int               c_CW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]      r_state;
    logic [7:0]      r_hold;
    logic            r_hold_full;
    logic [7:0]      r_shift;
    logic [2:0]      r_idx;
    logic [c_CW-1:0] r_baud;
    logic            r_ready;
    logic            r_int;
    logic            r_out;

    logic w_bit_end;
    logic w_load;
    logic w_write;

    assign w_bit_end = (r_baud == c_LAST);
    // Holding register empties either from idle or at the last stop-bit cycle.
    assign w_load    = r_hold_full &&
                       ((r_state == c_IDLE) || ((r_state == c_STOP) && w_bit_end));
    assign w_write   = tx_write && r_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_shift     <= 8'h00;
            r_idx       <= 3'd0;
            r_baud      <= '0;
            r_ready     <= 1'b1;
            r_int       <= 1'b0;
            r_out       <= 1'b1;
        end else begin
            r_int <= (r_state == c_STOP) && w_bit_end;

            if (w_load) begin
                r_hold_full <= 1'b0;
                r_ready     <= 1'b1;
            end else if (w_write) begin
                r_hold      <= tx_byte;
                r_hold_full <= 1'b1;
                r_ready     <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    r_baud <= '0;
                    r_out  <= 1'b1;
                    if (r_hold_full) begin
                        r_shift <= r_hold;
                        r_state <= c_START;
                        r_out   <= 1'b0;
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_idx   <= 3'd0;
                        r_state <= c_DATA;
                        r_out   <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + c_ONE;
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_idx == 3'd7) begin
                            r_state <= c_STOP;
                            r_out   <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_out <= r_shift[r_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + c_ONE;
                    end
                end
                c_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_hold_full) begin
                            r_shift <= r_hold;
                            r_state <= c_START;
                            r_out   <= 1'b0;
                        end else begin
                            r_state <= c_IDLE;
                            r_out   <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + c_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_out   <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign tx_int   = r_int;
    assign uart_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx at CLKS_PER_BIT = 4 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk;
    logic [1:0] rst_n;
    logic [1:0] wr;
    logic [7:0] wbyte [2];
    logic [1:0] ready;
    logic [1:0] tint;
    logic [1:0] out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q [2][$];
    logic [7:0] cur [2];
    bit   in_frame [2];
    bit   pulse_due [2];
    int   t [2];
    int   bad [2];
    int   gap [2];
    int   last_gap [2];
    int   frames [2];
    int   n_int [2];
    int   int_t [2];
    int   prev_int [2];
    int   cyc = 0;

    uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst_n[0]), .tx_write(wr[0]), .tx_byte(wbyte[0]),
        .tx_ready(ready[0]), .tx_int(tint[0]), .uart_out(out[0])
    );

    uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk(clk), .rst(rst_n[1]), .tx_write(wr[1]), .tx_byte(wbyte[1]),
        .tx_ready(ready[1]), .tx_int(tint[1]), .uart_out(out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a frame is start(0), 8 data bits LSB first, stop(1), each cpb cycles.
    initial begin
        for (int k = 0; k < 2; k++) begin
            in_frame[k] = 0; pulse_due[k] = 0; t[k] = 0; bad[k] = 0; gap[k] = 0;
            last_gap[k] = 0; frames[k] = 0; n_int[k] = 0; int_t[k] = 0; prev_int[k] = 0;
            cur[k] = 8'h00;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n[k]) begin
                    in_frame[k]  = 0;
                    pulse_due[k] = 0;
                    gap[k]       = 0;
                    exp_q[k].delete();
                end else begin
                    if (pulse_due[k] || tint[k]) begin
                        check($sformatf("tx_int_dut%0d", k), int'(tint[k]), int'(pulse_due[k]));
                        if (tint[k]) begin
                            n_int[k]++;
                            prev_int[k] = int_t[k];
                            int_t[k]    = cyc;
                        end
                    end
                    pulse_due[k] = 0;
                    if (!in_frame[k]) begin
                        if (out[k] == 1'b0) begin
                            if (exp_q[k].size() == 0) begin
                                check($sformatf("spurious_frame_dut%0d", k), 1, 0);
                                cur[k] = 8'h00;
                            end else begin
                                cur[k] = exp_q[k].pop_front();
                            end
                            in_frame[k] = 1;
                            t[k]        = 0;
                            bad[k]      = 0;
                            last_gap[k] = gap[k];
                        end else begin
                            gap[k]++;
                        end
                    end
                    if (in_frame[k]) begin
                        int  bp;
                        logic eb;
                        bp = t[k] / cpb(k);
                        if (bp == 0)      eb = 1'b0;
                        else if (bp == 9) eb = 1'b1;
                        else              eb = cur[k][bp-1];
                        if (out[k] !== eb) bad[k]++;
                        t[k]++;
                        if (t[k] == 10 * cpb(k)) begin
                            check($sformatf("frame_dut%0d_byte_%02h_bad_cycles", k, cur[k]), bad[k], 0);
                            in_frame[k]  = 0;
                            pulse_due[k] = 1;
                            gap[k]       = 0;
                            frames[k]++;
                        end
                    end
                end
            end
        end
    end

    task automatic do_write(input int k, input logic [7:0] b);
        exp_q[k].push_back(b);
        wr[k]    = 1'b1;
        wbyte[k] = b;
        @(negedge clk);
        wr[k]    = 1'b0;
    endtask

    task automatic junk_write(input int k, input logic [7:0] b);
        wr[k]    = 1'b1;
        wbyte[k] = b;
        @(negedge clk);
        wr[k]    = 1'b0;
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (!ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready[k]) check($sformatf("ready_timeout_dut%0d", k), 0, 1);
    endtask

    task automatic wait_tint(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tint[k] && n < 200);
        if (!tint[k]) check($sformatf("tint_timeout_dut%0d", k), 0, 1);
    endtask

    task automatic drain(input int k, input string name);
        int n = 0;
        while ((exp_q[k].size() != 0 || in_frame[k]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check($sformatf("%s_pending_frames_dut%0d", name, k), exp_q[k].size(), 0);
    endtask

    task automatic late_refill(input int k, input logic [7:0] a, input logic [7:0] b);
        do_write(k, a);
        wait_tint(k);
        repeat (10) @(negedge clk);
        do_write(k, b);
        drain(k, "late_refill");
        check($sformatf("late_refill_gap_dut%0d", k), last_gap[k], 12);
    endtask

    task automatic back_to_back(input int k, input logic [7:0] a, input logic [7:0] b);
        do_write(k, a);
        wait_ready(k);
        do_write(k, b);
        drain(k, "b2b");
        check($sformatf("b2b_gap_dut%0d", k), last_gap[k], 0);
        check($sformatf("b2b_int_spacing_dut%0d", k), int_t[k] - prev_int[k], 10 * cpb(k));
    endtask

    task automatic random_run(input int k, input int nbytes);
        int f0 = frames[k];
        for (int i = 0; i < nbytes; i++) begin
            int g = $urandom_range(0, 12);
            for (int j = 0; j < g; j++) begin
                if (!ready[k] && $urandom_range(0, 3) == 0)
                    junk_write(k, 8'($urandom));
                else
                    @(negedge clk);
            end
            wait_ready(k);
            do_write(k, 8'($urandom));
        end
        drain(k, "random");
        check($sformatf("random_frame_count_dut%0d", k), frames[k] - f0, nbytes);
    endtask

    initial begin
        int f0, i0;
        rst_n    = 2'b00;
        wr       = 2'b00;
        wbyte[0] = 8'h00;
        wbyte[1] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_out_dut%0d", k),   int'(out[k]),   1);
            check($sformatf("reset_ready_dut%0d", k), int'(ready[k]), 1);
            check($sformatf("reset_int_dut%0d", k),   int'(tint[k]),  0);
        end
        rst_n = 2'b11;
        repeat (3) @(negedge clk);

        // Single byte with latency checks.
        do_write(0, 8'hA5);
        check("lat_ready_low", int'(ready[0]), 0);
        check("lat_out_high_after_e0", int'(out[0]), 1);
        @(negedge clk);
        check("lat_out_low_after_e1", int'(out[0]), 0);
        check("lat_ready_high_after_e1", int'(ready[0]), 1);
        drain(0, "single");
        check("single_int_count", n_int[0], 1);

        back_to_back(0, 8'h00, 8'hFF);

        // Third write while hold is full must be dropped.
        f0 = frames[0];
        i0 = n_int[0];
        do_write(0, 8'h12);
        wait_ready(0);
        do_write(0, 8'h34);
        check("full_ready_low", int'(ready[0]), 0);
        junk_write(0, 8'h56);
        drain(0, "full");
        check("full_frame_count", frames[0] - f0, 2);
        check("full_int_count", n_int[0] - i0, 2);

        late_refill(0, 8'h3C, 8'hC3);

        // Reset mid-frame with a byte also waiting in the holding register.
        do_write(0, 8'h5A);
        wait_ready(0);
        do_write(0, 8'h77);
        repeat (15) @(negedge clk);
        #2 rst_n[0] = 1'b0;
        #1;
        check("midreset_out", int'(out[0]), 1);
        check("midreset_ready", int'(ready[0]), 1);
        check("midreset_int", int'(tint[0]), 0);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        f0 = frames[0];
        i0 = n_int[0];
        repeat (60) @(negedge clk);
        check("post_reset_frames", frames[0] - f0, 0);
        check("post_reset_ints", n_int[0] - i0, 0);
        check("post_reset_out", int'(out[0]), 1);

        late_refill(1, 8'h96, 8'h69);
        back_to_back(1, 8'h81, 8'h7E);

        random_run(0, 10);
        random_run(1, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter, the CPU-to-serial direction of the existing UART receive path. The CPU writes a byte with a one-cycle strobe into a single holding register. The block serialises it as 8N1, LSB first, on `uart_out`. It pulses `tx_int` at the end of every frame so the CPU can interrupt-drive transmission. The block sits beside the receiver in the CPU peripheral top level and shares the CPU clock.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud). Legal range ≥ 2. The baud counter is `$clog2(CLKS_PER_BIT)` bits wide.
- `clk` input 1: system clock. One clock domain; all logic on the rising edge.
- `rst` input 1: reset. Reset is asynchronous and active-low (0 = reset).
- `tx_write` input 1: CPU write strobe, one cycle. Sampled only when `tx_ready`=1.
- `tx_byte` input 8: byte to send. Captured on the edge where `tx_write`&&`tx_ready`.
- `tx_ready` output 1: holding register empty; the CPU may write.
- `tx_int` output 1: one-cycle pulse at the end of each frame's stop bit.
- `uart_out` output 1: serial line. Idle high.

## Operation
- Storage: `hold_reg`[7:0] + `hold_full`; `shift_reg`[7:0]; `bit_idx`[2:0]; `baud_cnt`. `tx_ready` = !`hold_full`, registered.
- Write: on an edge with `tx_write`=1 and `tx_ready`=1, set `hold_reg`←`tx_byte` and `hold_full`←1. A write while `tx_ready`=0 is ignored; the byte is dropped and no state changes.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_out`=1. If `hold_full`: set `shift_reg`←`hold_reg`, clear `hold_full`, `baud_cnt`←0, go to START.
  - START: `uart_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx`=0.
  - DATA: `uart_out`=`shift_reg[bit_idx]` for `CLKS_PER_BIT` cycles per bit. After bit 7 go to STOP.
  - STOP: `uart_out`=1 for `CLKS_PER_BIT` cycles. On the last cycle: assert `tx_int` for the next cycle. Then, if `hold_full`, load `shift_reg`, clear `hold_full` and go to START (back-to-back, no idle gap); else go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. Bit transitions happen only on wrap.
- Simultaneous events:
  - A write on the same edge that IDLE or STOP-end transfers hold→shift cannot occur, because `tx_ready`=0 while `hold_full`=1.
  - A write on the edge right after the transfer is accepted (`tx_ready` already 1).
- Double buffering: while a frame shifts, the CPU may preload one further byte.

## Timing
- Reset values (async, while `rst`=0):
  - outputs: `uart_out`=1, `tx_ready`=1, `tx_int`=0;
  - internal: FSM=IDLE, `hold_full`=0, `baud_cnt`=0, `bit_idx`=0.
- Reset mid-frame: the line returns high immediately, the frame is abandoned, and the held byte is lost.
- Latency:
  - write captured at edge E0; `tx_ready` falls after E0;
  - FSM enters START and `uart_out` falls after E1;
  - `tx_ready` rises again after E1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from `uart_out` falling to the end of the stop bit.
- `tx_int` high for exactly one cycle, the cycle after the last STOP cycle. For a back-to-back frame, this coincides with the first START cycle of the next frame.
- Continuous streaming: the throughput is one byte per 10×`CLKS_PER_BIT` cycles with no gap, provided the CPU refills within one frame.

## Test plan
- Reset: hold `rst`=0 mid-frame with `CLKS_PER_BIT`=4. Required: `uart_out`=1, `tx_ready`=1, `tx_int`=0 immediately. After release the line stays idle with no spurious frame.
- Single byte: write 0xA5 with `CLKS_PER_BIT`=4. Required:
  - `uart_out` low 1 cycle after capture, for 4 cycles;
  - then bits 1,0,1,0,0,1,0,1, each 4 cycles;
  - then high 4 cycles;
  - `tx_int` one pulse at cycle 41 after the fall; the line then stays idle.
- Back-to-back: write 0x00, then write 0xFF as soon as `tx_ready`=1. Required:
  - 80 contiguous bit-cycles; the stop bit of frame 1 is immediately followed by the start bit of frame 2;
  - two `tx_int` pulses 40 cycles apart.
- Write while full: write 0x12, then 0x34 (accepted into hold), then 0x56 while `tx_ready`=0. Required: frames 0x12 and 0x34 only; 0x56 never appears; exactly two `tx_int` pulses.
- Late refill: write 0x3C. After its `tx_int`, wait 10 cycles, then write 0xC3. Required: the line is high for the whole gap and the second frame is exact. Also run `CLKS_PER_BIT`=2 to confirm each bit lasts 2 cycles at the minimum legal value.
